// File: rtl/uidbuf_ic_pkg.sv
// Shared definitions for the UI-side FDMA buffer interconnects (read and write):
// requester count, FSM state encoding and a one-hot helper.
package uidbuf_ic_pkg;

    localparam int NREQ        = 4;
    localparam int REQ_IDX_W   = 2;
    localparam int BURST_LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } ic_state_t;

    function automatic logic [NREQ-1:0] req_onehot(input logic [REQ_IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way combinational round-robin picker: the search starts one past the
// last granted index and wraps, so the last winner has lowest priority.
module rr_arb4
    import uidbuf_ic_pkg::*;
(
    input  logic [NREQ-1:0]      req,
    input  logic [REQ_IDX_W-1:0] last,
    output logic [REQ_IDX_W-1:0] gnt,
    output logic                 any
);

    logic [REQ_IDX_W-1:0] idx;
    logic                 found;

    always_comb begin
        gnt   = last;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = last + REQ_IDX_W'(i);
            if (!found && req[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uidbufw_rr_interconnect.sv
// Round-robin interconnect sharing one FDMA write port among four requesters;
// address/size are latched at grant, data and beat strobes are muxed with zero latency.
module uidbufw_rr_interconnect
    import uidbuf_ic_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr_1,
    input  logic                      fdma_wareq_1,
    input  logic [BURST_LEN_W-1:0]    fdma_wsize_1,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata_1,
    output logic                      fdma_wbusy_1,
    output logic                      fdma_wvalid_1,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr_2,
    input  logic                      fdma_wareq_2,
    input  logic [BURST_LEN_W-1:0]    fdma_wsize_2,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata_2,
    output logic                      fdma_wbusy_2,
    output logic                      fdma_wvalid_2,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr_3,
    input  logic                      fdma_wareq_3,
    input  logic [BURST_LEN_W-1:0]    fdma_wsize_3,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata_3,
    output logic                      fdma_wbusy_3,
    output logic                      fdma_wvalid_3,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr_4,
    input  logic                      fdma_wareq_4,
    input  logic [BURST_LEN_W-1:0]    fdma_wsize_4,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata_4,
    output logic                      fdma_wbusy_4,
    output logic                      fdma_wvalid_4,

    output logic [AXI_ADDR_WIDTH-1:0] fdma_waddr,
    output logic                      fdma_wareq,
    output logic [BURST_LEN_W-1:0]    fdma_wsize,
    input  logic                      fdma_wbusy,
    input  logic                      fdma_wvalid,
    output logic [AXI_DATA_WIDTH-1:0] fdma_wdata,
    output logic [REQ_IDX_W-1:0]      grant_id
);

    ic_state_t                 state;
    ic_state_t                 state_nxt;
    logic [NREQ-1:0]           req;
    logic [REQ_IDX_W-1:0]      arb_gnt;
    logic                      arb_any;
    logic                      grant_take;
    logic                      busy_d;
    logic [NREQ-1:0]           wbusy_q;
    logic [NREQ-1:0]           wbusy_nxt;
    logic [NREQ-1:0]           wvalid_vec;

    logic [AXI_ADDR_WIDTH-1:0] req_addr [NREQ];
    logic [BURST_LEN_W-1:0]    req_size [NREQ];
    logic [AXI_DATA_WIDTH-1:0] req_data [NREQ];

    assign req = {fdma_wareq_4, fdma_wareq_3, fdma_wareq_2, fdma_wareq_1};

    assign req_addr[0] = fdma_waddr_1;
    assign req_addr[1] = fdma_waddr_2;
    assign req_addr[2] = fdma_waddr_3;
    assign req_addr[3] = fdma_waddr_4;
    assign req_size[0] = fdma_wsize_1;
    assign req_size[1] = fdma_wsize_2;
    assign req_size[2] = fdma_wsize_3;
    assign req_size[3] = fdma_wsize_4;
    assign req_data[0] = fdma_wdata_1;
    assign req_data[1] = fdma_wdata_2;
    assign req_data[2] = fdma_wdata_3;
    assign req_data[3] = fdma_wdata_4;

    rr_arb4 u_arb (
        .req  (req),
        .last (grant_id),
        .gnt  (arb_gnt),
        .any  (arb_any)
    );

    assign grant_take = (state == ST_IDLE) && arb_any;

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero-length burst is acknowledged through DONE without touching the FDMA.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (arb_any) state_nxt = (req_size[arb_gnt] == '0) ? ST_DONE : ST_REQ;
            ST_REQ:  if (fdma_wbusy) state_nxt = ST_BUSY;
            ST_BUSY: if (busy_d && !fdma_wbusy) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wbusy_nxt  = '0;
        wvalid_vec = '0;
        fdma_wdata = '0;
        if (grant_take) begin
            wbusy_nxt = req_onehot(arb_gnt);
        end else if (state_nxt == ST_REQ || state_nxt == ST_BUSY) begin
            wbusy_nxt = req_onehot(grant_id);
        end
        if (fdma_wvalid && (state == ST_REQ || state == ST_BUSY)) begin
            wvalid_vec = req_onehot(grant_id);
        end
        if (state != ST_IDLE) begin
            fdma_wdata = req_data[grant_id];
        end
    end

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            busy_d     <= 1'b0;
            fdma_wareq <= 1'b0;
            fdma_waddr <= '0;
            fdma_wsize <= '0;
            wbusy_q    <= '0;
            grant_id   <= REQ_IDX_W'(NREQ - 1);
        end else begin
            busy_d     <= fdma_wbusy;
            fdma_wareq <= (state_nxt == ST_REQ);
            wbusy_q    <= wbusy_nxt;
            if (grant_take) begin
                fdma_waddr <= req_addr[arb_gnt];
                fdma_wsize <= req_size[arb_gnt];
                grant_id   <= arb_gnt;
            end
        end
    end

    assign fdma_wbusy_1  = wbusy_q[0];
    assign fdma_wbusy_2  = wbusy_q[1];
    assign fdma_wbusy_3  = wbusy_q[2];
    assign fdma_wbusy_4  = wbusy_q[3];
    assign fdma_wvalid_1 = wvalid_vec[0];
    assign fdma_wvalid_2 = wvalid_vec[1];
    assign fdma_wvalid_3 = wvalid_vec[2];
    assign fdma_wvalid_4 = wvalid_vec[3];

endmodule

// File: tb/tb_uidbufw_rr_interconnect.sv
// Bench for uidbufw_rr_interconnect: requester and FDMA slave models drive random
// bursts; grants, latched fields, beat strobes and data are checked against a reference.
module tb_uidbufw_rr_interconnect;

    localparam int DW   = 128;
    localparam int AW   = 32;
    localparam int MAXB = 4;

    logic ui_clk = 1'b0;
    logic ui_rst;
    always #5 ui_clk = ~ui_clk;

    logic [AW-1:0] waddr [4];
    logic [15:0]   wsize [4];
    logic [DW-1:0] wdata [4];
    logic [3:0]    wareq;
    wire  [3:0]    wbusy_n;
    wire  [3:0]    wvalid_n;

    wire  [AW-1:0] fdma_waddr;
    wire           fdma_wareq;
    wire  [15:0]   fdma_wsize;
    logic          fdma_wbusy;
    logic          fdma_wvalid;
    wire  [DW-1:0] fdma_wdata;
    wire  [1:0]    grant_id;

    uidbufw_rr_interconnect #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .ui_clk        (ui_clk),
        .ui_rst        (ui_rst),
        .fdma_waddr_1  (waddr[0]),
        .fdma_wareq_1  (wareq[0]),
        .fdma_wsize_1  (wsize[0]),
        .fdma_wdata_1  (wdata[0]),
        .fdma_wbusy_1  (wbusy_n[0]),
        .fdma_wvalid_1 (wvalid_n[0]),
        .fdma_waddr_2  (waddr[1]),
        .fdma_wareq_2  (wareq[1]),
        .fdma_wsize_2  (wsize[1]),
        .fdma_wdata_2  (wdata[1]),
        .fdma_wbusy_2  (wbusy_n[1]),
        .fdma_wvalid_2 (wvalid_n[1]),
        .fdma_waddr_3  (waddr[2]),
        .fdma_wareq_3  (wareq[2]),
        .fdma_wsize_3  (wsize[2]),
        .fdma_wdata_3  (wdata[2]),
        .fdma_wbusy_3  (wbusy_n[2]),
        .fdma_wvalid_3 (wvalid_n[2]),
        .fdma_waddr_4  (waddr[3]),
        .fdma_wareq_4  (wareq[3]),
        .fdma_wsize_4  (wsize[3]),
        .fdma_wdata_4  (wdata[3]),
        .fdma_wbusy_4  (wbusy_n[3]),
        .fdma_wvalid_4 (wvalid_n[3]),
        .fdma_waddr    (fdma_waddr),
        .fdma_wareq    (fdma_wareq),
        .fdma_wsize    (fdma_wsize),
        .fdma_wbusy    (fdma_wbusy),
        .fdma_wvalid   (fdma_wvalid),
        .fdma_wdata    (fdma_wdata),
        .grant_id      (grant_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          nb [4];
    int          bi [4];
    int          bsz [4][MAXB];
    int          beat_idx [4];
    bit          active [4];
    bit          adv [4];
    int          last_g;
    int          cur;
    int          cur_beats;
    int          cur_busy_cyc;
    bit          cur_wareq_seen;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_size;
    logic [3:0]    prev_busy;
    bit          sl_busy;
    bit          sl_chk_drop;
    int          sl_left;
    int          sl_dly;
    int          glog[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dpat(input int n, input int b, input int k);
        return {32'hC0DE_0000 | 32'(n), 32'(b), 32'(k), ~32'(k)};
    endfunction

    function automatic logic [AW-1:0] apat(input int n, input int b);
        return AW'(32'h1000 * (n + 1) + 32'h100 * b);
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    // First waiting requester after the previous winner, wrapping around.
    function automatic int rr_pick(input logic [3:0] m, input int lst);
        for (int k = 1; k <= 4; k++) begin
            if (m[(lst + k) % 4]) return (lst + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit all_done();
        for (int n = 0; n < 4; n++) begin
            if (bi[n] != nb[n] || wareq[n] || active[n]) return 1'b0;
        end
        return (cur < 0) && !sl_busy && (prev_busy == 4'd0);
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            nb[n] = 0; bi[n] = 0; beat_idx[n] = 0; active[n] = 0; adv[n] = 0;
            wareq[n] = 1'b0;
            waddr[n] = apat(n, 0);
            wsize[n] = 16'd0;
            wdata[n] = dpat(n, 0, 0);
        end
        last_g = 3; cur = -1; prev_busy = 4'd0;
        sl_busy = 0; sl_chk_drop = 0; sl_left = 0; sl_dly = 0;
        fdma_wbusy = 1'b0; fdma_wvalid = 1'b0;
        glog.delete();
    endtask

    task automatic new_scenario();
        for (int n = 0; n < 4; n++) begin
            nb[n] = 0; bi[n] = 0;
        end
        glog.delete();
    endtask

    task automatic add_burst(input int n, input int sz);
        bsz[n][nb[n]] = sz;
        nb[n]++;
    endtask

    task automatic step();
        logic [3:0] bz;
        int w;
        @(negedge ui_clk);
        bz = wbusy_n;
        if (bz != 4'd0 && prev_busy == 4'd0) begin
            w = rr_pick(wareq, last_g);
            if (w < 0) begin
                chk("spurious_grant", 128'(bz), 128'(0));
            end else begin
                chk("grant_vec", 128'(bz), 128'(oh(w)));
                chk("grant_id", 128'(grant_id), 128'(w));
                chk("grant_addr", 128'(fdma_waddr), 128'(waddr[w]));
                chk("grant_size", 128'(fdma_wsize), 128'(wsize[w]));
                chk("wareq_at_grant", 128'(fdma_wareq), 128'(wsize[w] != 16'd0));
                last_g = w; cur = w; exp_addr = waddr[w]; exp_size = wsize[w];
                cur_beats = 0; cur_busy_cyc = 0; cur_wareq_seen = 0;
                glog.push_back(w);
            end
        end
        if (cur >= 0) begin
            if (bz != 4'd0) begin
                chk("busy_vec", 128'(bz), 128'(oh(cur)));
                cur_busy_cyc++;
            end
            if (fdma_wareq) cur_wareq_seen = 1;
            if (bz == 4'd0 && prev_busy != 4'd0) begin
                chk("beats", 128'(cur_beats), 128'(exp_size));
                chk("addr_hold", 128'(fdma_waddr), 128'(exp_addr));
                chk("size_hold", 128'(fdma_wsize), 128'(exp_size));
                if (exp_size == 16'd0) begin
                    chk("zero_busy_cycles", 128'(cur_busy_cyc), 128'(1));
                    chk("zero_no_wareq", 128'(cur_wareq_seen), 128'(0));
                end
                cur = -1;
            end
        end
        if (sl_chk_drop) begin
            chk("wareq_drop", 128'(fdma_wareq), 128'(0));
            sl_chk_drop = 0;
        end
        prev_busy = bz;

        // Requesters: hold request until busy is seen, scramble inputs afterwards.
        for (int n = 0; n < 4; n++) begin
            if (adv[n]) begin
                beat_idx[n]++;
                wdata[n] = dpat(n, bi[n], beat_idx[n]);
                adv[n] = 0;
            end
            if (bz[n]) begin
                if (wareq[n]) begin
                    wareq[n] = 1'b0;
                    waddr[n] = $urandom;
                    wsize[n] = 16'($urandom);
                end
                active[n] = 1;
            end else begin
                if (active[n]) begin
                    active[n] = 0; bi[n]++; beat_idx[n] = 0;
                end
                if (!wareq[n] && bi[n] < nb[n]) begin
                    waddr[n] = apat(n, bi[n]);
                    wsize[n] = 16'(bsz[n][bi[n]]);
                    wdata[n] = dpat(n, bi[n], 0);
                    wareq[n] = 1'b1;
                end
            end
        end

        // FDMA slave: random grant delay, then exactly fdma_wsize beats with gaps.
        if (!sl_busy) begin
            fdma_wvalid = 1'b0;
            if (fdma_wareq) begin
                if (sl_dly == 0) begin
                    fdma_wbusy = 1'b1; sl_busy = 1; sl_left = int'(fdma_wsize);
                    sl_chk_drop = 1; sl_dly = $urandom_range(0, 2);
                end else begin
                    sl_dly--;
                end
            end
        end else if (sl_left == 0) begin
            fdma_wbusy = 1'b0; fdma_wvalid = 1'b0; sl_busy = 0;
        end else begin
            fdma_wvalid = ($urandom_range(0, 3) != 0);
            if (fdma_wvalid) sl_left--;
        end

        #1;
        chk("wvalid_vec", 128'(wvalid_n), 128'((fdma_wvalid && cur >= 0) ? oh(cur) : 4'd0));
        if (fdma_wvalid && cur >= 0) begin
            chk("wdata", fdma_wdata, dpat(cur, bi[cur], cur_beats));
            if (wvalid_n[cur]) begin
                cur_beats++;
                adv[cur] = 1;
            end
        end
    endtask

    task automatic run_all(input int max_cyc);
        int c;
        c = 0;
        step();
        c++;
        while (!all_done() && c < max_cyc) begin
            step();
            c++;
        end
        chk("run_complete", 128'(all_done()), 128'(1));
    endtask

    task automatic hard_reset();
        ui_rst = 1'b1;
        model_reset();
        @(negedge ui_clk);
        ui_rst = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wbusy"}, 128'(wbusy_n), 128'(0));
        chk({tag, "_wvalid"}, 128'(wvalid_n), 128'(0));
        chk({tag, "_wareq"}, 128'(fdma_wareq), 128'(0));
        chk({tag, "_waddr"}, 128'(fdma_waddr), 128'(0));
        chk({tag, "_wsize"}, 128'(fdma_wsize), 128'(0));
        chk({tag, "_wdata"}, fdma_wdata, 128'(0));
        chk({tag, "_grant_id"}, 128'(grant_id), 128'(3));
    endtask

    initial begin
        int c;
        ui_rst = 1'b1;
        model_reset();
        repeat (3) @(negedge ui_clk);
        fdma_wvalid = 1'b1;
        #1;
        chk_outputs_zero("reset");
        @(negedge ui_clk);
        fdma_wvalid = 1'b0;
        ui_rst = 1'b0;

        // Stray beat strobe while idle
        @(negedge ui_clk);
        fdma_wvalid = 1'b1;
        #1;
        chk("idle_wvalid", 128'(wvalid_n), 128'(0));
        chk("idle_wdata", fdma_wdata, 128'(0));
        @(negedge ui_clk);
        fdma_wvalid = 1'b0;
        chk("idle_wbusy", 128'(wbusy_n), 128'(0));
        chk("idle_wareq", 128'(fdma_wareq), 128'(0));
        chk("idle_grant_id", 128'(grant_id), 128'(3));

        // Single 16-beat burst from requester 1 at 0x1000
        new_scenario();
        add_burst(0, 16);
        run_all(300);
        chk("single_grants", 128'(glog.size()), 128'(1));
        if (glog.size() > 0) chk("single_winner", 128'(glog[0]), 128'(0));

        // All four requesting from reset
        hard_reset();
        new_scenario();
        add_burst(0, 1 + $urandom_range(0, 5));
        add_burst(0, 1 + $urandom_range(0, 5));
        for (int n = 1; n < 4; n++) add_burst(n, 1 + $urandom_range(0, 5));
        run_all(600);
        chk("rr_grants", 128'(glog.size()), 128'(5));
        for (int k = 0; k < 5 && k < glog.size(); k++) chk("rr_order", 128'(glog[k]), 128'(k % 4));

        // Requester 3 leaves grant_id=2, then 2 and 4 contend
        new_scenario();
        add_burst(2, 3);
        run_all(200);
        chk("gid_after_3", 128'(grant_id), 128'(2));
        new_scenario();
        add_burst(1, 4);
        add_burst(3, 4);
        run_all(300);
        chk("contend_grants", 128'(glog.size()), 128'(2));
        if (glog.size() == 2) begin
            chk("contend_first", 128'(glog[0]), 128'(3));
            chk("contend_second", 128'(glog[1]), 128'(1));
        end

        // Zero-length burst from requester 3
        new_scenario();
        add_burst(2, 0);
        run_all(100);
        chk("zero_gid", 128'(grant_id), 128'(2));

        // Reset in the middle of a 16-beat burst
        hard_reset();
        new_scenario();
        add_burst(0, 16);
        c = 0;
        while (cur_beats < 5 && c < 200) begin
            step();
            c++;
        end
        chk("midrst_reached", 128'(cur_beats >= 5), 128'(1));
        fdma_wvalid = 1'b1;
        ui_rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        @(negedge ui_clk);
        chk("midrst_wvalid_held", 128'(wvalid_n), 128'(0));
        model_reset();
        ui_rst = 1'b0;
        new_scenario();
        add_burst(0, 3);
        add_burst(1, 3);
        run_all(300);
        chk("post_rst_grants", 128'(glog.size()), 128'(2));
        if (glog.size() > 0) chk("post_rst_first", 128'(glog[0]), 128'(0));

        // Random mixes including zero-length bursts
        repeat (8) begin
            new_scenario();
            for (int n = 0; n < 4; n++) begin
                int k;
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) add_burst(n, $urandom_range(0, 8));
            end
            run_all(3000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uidbufw_rr_interconnect.md
UIDBUFW_RR_INTERCONNECT -- requirements
Module: uidbufw_rr_interconnect

Interface
REQ-001 Parameter AXI_DATA_WIDTH, 128, FDMA write data width.
REQ-002 Parameter AXI_ADDR_WIDTH, 32, FDMA write address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 ui_clk  in  1  sole clock; all flops rise-edge.
REQ-005 ui_rst  in  1  asynchronous active-high reset.
REQ-006 fdma_waddr_n (n=1..4)  in  AXI_ADDR_WIDTH  requester n burst start address.
REQ-007 fdma_wareq_n  in  1  requester n write request, level, held until fdma_wbusy_n seen high.
REQ-008 fdma_wsize_n  in  16  requester n burst length in beats.
REQ-009 fdma_wdata_n  in  AXI_DATA_WIDTH  requester n write data for the current beat.
REQ-010 fdma_wbusy_n  out  1  requester n granted and in progress.
REQ-011 fdma_wvalid_n  out  1  beat strobe to requester n; requester advances its data on it.
REQ-012 fdma_waddr / fdma_wareq / fdma_wsize  out  AXI_ADDR_WIDTH/1/16  shared FDMA write request.
REQ-013 fdma_wbusy  in  1  FDMA write in progress.
REQ-014 fdma_wvalid  in  1  FDMA accepts one beat of fdma_wdata this cycle.
REQ-015 fdma_wdata  out  AXI_DATA_WIDTH  shared FDMA write data.
REQ-016 grant_id  out  2  index of the current or last granted requester (0..3 = n-1).

Function
REQ-017 The FSM SHALL have exactly the states IDLE, REQ, BUSY, DONE.
REQ-018 IDLE: on any asserted fdma_wareq_n, select the first asserted requester in round-robin order starting at grant_id+1 (mod 4), then go to REQ.
REQ-019 On the IDLE->REQ transition, latch fdma_waddr_n and fdma_wsize_n of the winner into fdma_waddr/fdma_wsize and update grant_id.
REQ-020 REQ: fdma_wareq=1 registered; on fdma_wbusy=1 drop fdma_wareq next cycle and go to BUSY.
REQ-021 BUSY: on the fdma_wbusy falling edge (registered 1, now 0) go to DONE.
REQ-022 DONE: one cycle with all fdma_wbusy_n=0, then IDLE. This guarantees a requester can deassert fdma_wareq_n before re-arbitration.
REQ-023 fdma_wbusy_n SHALL be registered 1 for the granted n from the cycle after the IDLE->REQ transition through the BUSY->DONE transition, and 0 for all other n.
REQ-024 fdma_wdata SHALL be a combinational mux of fdma_wdata_n by grant_id (zero latency); it is 0 in IDLE.
REQ-025 fdma_wvalid_n SHALL be combinational: fdma_wvalid AND (state in REQ or BUSY) AND (grant_id==n-1).
REQ-026 fdma_wsize_n==0: the grant SHALL skip REQ/BUSY (IDLE->DONE) with fdma_wbusy_n pulsed for one cycle and no FDMA request issued.
REQ-027 Simultaneous requests: exactly one winner per round-robin order; losers wait with fdma_wbusy_n=0.
REQ-028 Requester inputs changing after latch SHALL NOT alter fdma_waddr/fdma_wsize.
REQ-029 fdma_wvalid outside REQ/BUSY SHALL be ignored (no fdma_wvalid_n asserted).

Reset
REQ-030 On ui_rst=1, immediately set state=IDLE, fdma_wareq=0, fdma_waddr=0, fdma_wsize=0, all fdma_wbusy_n=0, grant_id=3 (requester 1 first).
REQ-031 Reset mid-burst SHALL abandon the transfer; no fdma_wvalid_n SHALL be asserted while ui_rst=1.

Structure
REQ-032 State encodings and the number of requesters (4) SHALL live in a shared package/header uidbuf_ic_pkg, reused by the read interconnect.
REQ-033 Round-robin selection SHALL be one sub-module rr_arb4 (req[3:0], last[1:0] -> gnt[1:0], any), combinational.

Verification
REQ-034 Single: wareq_1=1, waddr_1=0x1000, wsize_1=16; FDMA drives busy for 16 wvalid beats -> fdma_waddr=0x1000, fdma_wsize=16, 16 fdma_wvalid_1 pulses, fdma_wdata=fdma_wdata_1 each beat, wbusy_1 falls, DONE one cycle.
REQ-035 All four wareq_n held from reset -> grant order 1,2,3,4,1; grant_id 0,1,2,3,0.
REQ-036 wareq_2 and wareq_4 asserted with grant_id=2 -> requester 4 granted first, then 2.
REQ-037 wsize_3=0 -> fdma_wareq never asserted, wbusy_3 high one cycle, grant_id=2.
REQ-038 ui_rst asserted mid-BUSY after 5 of 16 beats -> all outputs zero immediately, grant_id=3; after release requester 1 wins first.
REQ-039 fdma_wvalid pulsed in IDLE -> no fdma_wvalid_n asserted, state unchanged.
